sub_bytes_engine: RTL and testbench
===================================

// Module: sub_bytes_engine
// PURPOSE
//  Multi-beat AES SubBytes unit: takes a BLOCK_BYTES-byte state over valid/ready and substitutes LANES bytes per cycle.
//  Lookups use a LANES-port registered S-box ROM. The result is returned over valid/ready.
//  Sits between the SIMD register file and the ShiftRows/MixColumns stages of the AES datapath.
//  Successor to the 4-port combinational s_box: adds parametrised lane count, pipelining, handshakes and inverse mode.
// PARAMETERS
//  BLOCK_BYTES    16              bytes per state; must be a multiple of LANES
//  LANES          4               bytes substituted per cycle (1,2,4,8,16)
//  SBOX_FILE      "sbox.dat"      $readmemh image, forward table (256 x 8)
//  INV_SBOX_FILE  "inv_sbox.dat"  $readmemh image, inverse table (used only with SBOX_INV_EN)
// PORTS
//  clk        in   1               rising-edge clock
//  rst        in   1               synchronous, active-high reset
//  in_valid   in   1               input state valid
//  in_ready   out  1               engine can accept a state
//  in_data    in   8*BLOCK_BYTES   byte i = in_data[8*i+7:8*i]
//  in_inv     in   1               1 = inverse S-box (InvSubBytes)
//  out_valid  out  1               result valid
//  out_ready  in   1               consumer accepts result
//  out_data   out  8*BLOCK_BYTES   substituted state, same byte order as in_data
//  busy       out  1               high in any state other than IDLE
// BEHAVIOUR
//  - BEATS = BLOCK_BYTES/LANES; beat k covers bytes k*LANES .. k*LANES+LANES-1.
//  - FSM: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
//  - IDLE: in_ready=1.
//    - On in_valid&in_ready, latch in_data into the state buffer and in_inv into the mode flag; beat counter := 0; go to ISSUE.
//  - ISSUE: drive the LANES ROM addresses from beat k of the buffer; counter++.
//    - Leave for DRAIN after beat BEATS-1 is issued (BEATS cycles in ISSUE).
//  - ROM output is registered: data for beat k is valid one cycle after issue.
//    - It is written back into buffer beat k on the following edge, so write-back of beat k happens while beat k+1 issues.
//  - DRAIN: 1 cycle; writes back the last beat; go to DONE.
//  - DONE: out_valid=1 and out_data=buffer, held stable until out_ready; on out_valid&out_ready go to IDLE.
//  - Latency: with the accept edge as edge 0, out_valid=1 after edge BEATS+1 (edge 5 for defaults).
//  - Throughput: one state per BEATS+3 cycles with out_ready tied high.
//  - in_ready=0 outside IDLE; in_valid is ignored there, with no overlap and no queueing.
//  - Back-pressure: in DONE with out_ready=0, the engine stalls indefinitely; out_data does not change.
//  - in_inv is sampled only at accept; changes mid-operation have no effect.
//  - LANES=BLOCK_BYTES: BEATS=1 (one ISSUE cycle, then DRAIN).
//  - Counter width = max(1,$clog2(BEATS)); it saturates and never wraps past BEATS-1.
//  - Reset (at any time, including mid-ISSUE/DONE):
//    - state=IDLE; in_ready=1; out_valid=0; busy=0; counter=0; mode flag=0; buffer and out_data cleared to 0.
//    - Any in-flight result is discarded.
// CONFIGURATION
//  SBOX_INV_EN defined:
//    - Instantiate the inverse ROM as well; the latched mode selects the table per state.
//  SBOX_INV_EN undefined:
//    - Only the forward ROM exists; in_inv is ignored and the mode flag is tied to 0.
// STRUCTURE
//  aes_pkg:
//    - byte_t (logic [7:0]); sbe_state_e {IDLE,ISSUE,DRAIN,DONE}; AES_BLOCK_BYTES=16.
//    - Constant SBOX_ROM_DEPTH=256.
//  Sub-module sbox_rom #(LANES, INIT_FILE):
//    - LANES read ports, 8-bit address and data; one registered output stage; no write port.
//    - One instance for the forward table; a second instance under SBOX_INV_EN.
//  The top holds the FSM, beat counter, buffer and write-back mux.
// TESTING
//  1. Forward: in_data bytes 00..0f, in_inv=0, out_ready=1.
//     -> out bytes 63 7c 77 7b f2 6b 6f c5 30 01 67 2b fe d7 ab 76; out_valid after edge 5.
//  2. Inverse (SBOX_INV_EN): feed the result of test 1 with in_inv=1 -> out bytes 00..0f.
//     Without the macro the same stimulus returns the forward S-box of each byte.
//  3. Back-pressure: hold out_ready=0 for 10 cycles in DONE.
//     -> out_valid stays 1, out_data is unchanged, in_ready=0.
//     Release -> IDLE next cycle with in_ready=1.
//  4. Reset mid-op: rst=1 during the 2nd ISSUE cycle.
//     -> next cycle in_ready=1, out_valid=0, busy=0, out_data=0.
//     A new state then completes correctly.
//  5. Ignore while busy: pulse in_valid with a different in_data during ISSUE.
//     -> the result matches only the first state; the second is not latched.
//  6. Sweep LANES=1,2,16 with all-0x53 input -> every out byte = ed; latency BEATS+1 (16, 8, 1 beat).

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types, FSM encoding and the S-box table generator used by sub_bytes_engine.
// The tables are built at elaboration from GF(2^8) arithmetic.
package aes_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sbe_state_e;

  localparam int AES_BLOCK_BYTES = 16;
  localparam int SBOX_ROM_DEPTH  = 256;

  function automatic byte_t xtime(input byte_t a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t gf_mul(input byte_t a, input byte_t b);
    byte_t p;
    byte_t x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
  function automatic byte_t gf_inv(input byte_t a);
    byte_t r;
    byte_t base;
    logic [7:0] e;
    r    = 8'h01;
    base = a;
    e    = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gf_mul(r, base);
      base = gf_mul(base, base);
    end
    return r;
  endfunction

  function automatic byte_t rotl(input byte_t b, input int n);
    byte_t r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic byte_t fwd_sbox(input byte_t x);
    byte_t b;
    b = gf_inv(x);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic byte_t inv_sbox(input byte_t x);
    return gf_inv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [SBOX_ROM_DEPTH*8-1:0] build_table(input bit inverse);
    logic [SBOX_ROM_DEPTH*8-1:0] t;
    t = '0;
    for (int i = 0; i < SBOX_ROM_DEPTH; i++) begin
      t[i*8 +: 8] = inverse ? inv_sbox(byte_t'(i)) : fwd_sbox(byte_t'(i));
    end
    return t;
  endfunction

endpackage

// File: rtl/sbox_rom.sv
// LANES-port S-box ROM with one registered output stage; no write port.
// The instance serves the inverse table when its image name equals the inverse image name.
module sbox_rom
  import aes_pkg::*;
#(
  parameter int    LANES     = 4,
  parameter string INIT_FILE = "sbox.dat",
  parameter string INV_FILE  = "inv_sbox.dat"
) (
  input  logic               clk,
  input  logic [LANES*8-1:0] addr,
  output logic [LANES*8-1:0] data
);

  localparam bit INVERSE = (INIT_FILE == INV_FILE);
  localparam logic [SBOX_ROM_DEPTH*8-1:0] TABLE = build_table(INVERSE);

  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      data[l*8 +: 8] <= TABLE[{addr[l*8 +: 8], 3'b000} +: 8];
    end
  end

endmodule

// File: rtl/sub_bytes_engine.sv
// Multi-beat AES SubBytes: substitutes LANES bytes per cycle of a BLOCK_BYTES state.
// Define SBOX_INV_EN to add the inverse ROM and honour in_inv (InvSubBytes).
module sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int    BLOCK_BYTES   = AES_BLOCK_BYTES,
  parameter int    LANES         = 4,
  parameter string SBOX_FILE     = "sbox.dat",
  parameter string INV_SBOX_FILE = "inv_sbox.dat"
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [8*BLOCK_BYTES-1:0] in_data,
  input  logic                     in_inv,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [8*BLOCK_BYTES-1:0] out_data,
  output logic                     busy,
  output logic [1:0]               state_dbg
);

  localparam int BEATS = BLOCK_BYTES / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LW    = LANES * 8;
  localparam int BW    = BLOCK_BYTES * 8;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  sbe_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] wb_beat_q;
  logic          wb_valid_q;
  logic [BW-1:0] buf_q;
  logic [LW-1:0] rom_addr;
  logic [LW-1:0] fwd_q;
  logic [LW-1:0] rom_q;
  logic          accept;

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid
  // never depends on ready, and out_data is held stable while out_valid waits.
  assign accept    = in_valid && in_ready;
  assign rom_addr  = buf_q[int'(cnt_q)*LW +: LW];
  assign out_data  = buf_q;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ISSUE;
      end
      ISSUE: if (cnt_q == LAST) state_d = DRAIN;
      DRAIN: state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Beat k is read from the ROM one cycle and written back the next, so the
  // write-back of beat k overlaps the issue of beat k+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wb_beat_q  <= '0;
      wb_valid_q <= 1'b0;
      buf_q      <= '0;
    end else begin
      state_q    <= state_d;
      wb_valid_q <= (state_q == ISSUE);
      wb_beat_q  <= cnt_q;
      if (accept) begin
        buf_q <= in_data;
        cnt_q <= '0;
      end else begin
        if (state_q == ISSUE && cnt_q != LAST) cnt_q <= cnt_q + 1'b1;
        if (wb_valid_q) buf_q[int'(wb_beat_q)*LW +: LW] <= rom_q;
      end
    end
  end

  sbox_rom #(
    .LANES    (LANES),
    .INIT_FILE(SBOX_FILE),
    .INV_FILE (INV_SBOX_FILE)
  ) u_fwd_rom (
    .clk (clk),
    .addr(rom_addr),
    .data(fwd_q)
  );

`ifdef SBOX_INV_EN
  logic          mode_q;
  logic [LW-1:0] inv_q;

  always_ff @(posedge clk) begin
    if (rst)         mode_q <= 1'b0;
    else if (accept) mode_q <= in_inv;
  end

  sbox_rom #(
    .LANES    (LANES),
    .INIT_FILE(INV_SBOX_FILE),
    .INV_FILE (INV_SBOX_FILE)
  ) u_inv_rom (
    .clk (clk),
    .addr(rom_addr),
    .data(inv_q)
  );

  assign rom_q = mode_q ? inv_q : fwd_q;
`else
  logic unused_in_inv;
  assign unused_in_inv = in_inv;
  assign rom_q         = fwd_q;
`endif

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Directed bench for sub_bytes_engine: vector table plus back-pressure, reset,
// busy-ignore and LANES sweep sequences.
module tb_sub_bytes_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_inv;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
  logic [1:0]   state_dbg;

  logic         sw_valid;
  logic [127:0] sw_data;
  logic         sw_ready  [3];
  logic         sw_ovalid [3];
  logic [127:0] sw_odata  [3];
  logic         sw_busy   [3];
  logic [1:0]   sw_dbg    [3];

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] FWD_0F = 128'h76abd7fe2b670130c56f6bf27b777c63;
  localparam logic [127:0] SEQ_0F = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] SEQ_1F = 128'h1f1e1d1c1b1a19181716151413121110;
  localparam logic [127:0] FWD_1F = 128'hc072a49cafa2d4adf04759fa7dc982ca;
`ifdef SBOX_INV_EN
  localparam logic [127:0] EXP_RT = SEQ_0F;
  localparam logic [127:0] EXP_63 = {16{8'h00}};
`else
  localparam logic [127:0] EXP_RT = 128'h38620ebbf1857c04a6a87f8921f510fb;
  localparam logic [127:0] EXP_63 = {16{8'hfb}};
`endif

  sub_bytes_engine dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy), .state_dbg(state_dbg)
  );

  sub_bytes_engine #(.LANES(1)) u_l1 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_ready[0]),
    .in_data(sw_data), .in_inv(1'b0), .out_valid(sw_ovalid[0]),
    .out_ready(1'b1), .out_data(sw_odata[0]), .busy(sw_busy[0]), .state_dbg(sw_dbg[0])
  );

  sub_bytes_engine #(.LANES(2)) u_l2 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_ready[1]),
    .in_data(sw_data), .in_inv(1'b0), .out_valid(sw_ovalid[1]),
    .out_ready(1'b1), .out_data(sw_odata[1]), .busy(sw_busy[1]), .state_dbg(sw_dbg[1])
  );

  sub_bytes_engine #(.LANES(16)) u_l16 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_ready[2]),
    .in_data(sw_data), .in_inv(1'b0), .out_valid(sw_ovalid[2]),
    .out_ready(1'b1), .out_data(sw_odata[2]), .busy(sw_busy[2]), .state_dbg(sw_dbg[2])
  );

  typedef struct {
    string        name;
    logic [127:0] din;
    logic         inv;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Counts edges until out_valid is seen (sampled 1 time unit after each edge), bounded.
  task automatic wait_valid(inout int lat);
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
    end
  endtask

  task automatic run_state(input logic [127:0] d, input logic inv,
                           output logic [127:0] res, output int lat);
    @(negedge clk);
    in_data   = d;
    in_inv    = inv;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_inv   = ~inv;
    lat      = 0;
    wait_valid(lat);
    res = out_valid ? out_data : '0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] res;
    int           lat;
    logic [127:0] hold;
    int           sl [3];
    logic [127:0] sd [3];
    int           exp_lat [3];

    vecs[0] = '{"fwd_00_0f", SEQ_0F,              1'b0, FWD_0F};
    vecs[1] = '{"inv_rt",    FWD_0F,              1'b1, EXP_RT};
    vecs[2] = '{"zeros",     128'h0,              1'b0, {16{8'h63}}};
    vecs[3] = '{"ones",      {16{8'hff}},         1'b0, {16{8'h16}}};
    vecs[4] = '{"fwd_10_1f", SEQ_1F,              1'b0, FWD_1F};
    vecs[5] = '{"inv_63",    {16{8'h63}},         1'b1, EXP_63};
    vecs[6] = '{"all_53",    {16{8'h53}},         1'b0, {16{8'hed}}};

    rst = 1'b1; in_valid = 1'b0; in_inv = 1'b0; in_data = '0; out_ready = 1'b0;
    sw_valid = 1'b0; sw_data = {16{8'h53}};
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 128'(in_ready), 128'd1);
    check("rst_valid", 128'(out_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_data", out_data, 128'd0);
    check("rst_state", 128'(state_dbg), 128'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_state(vecs[i].din, vecs[i].inv, res, lat);
      check({vecs[i].name, "_data"}, res, vecs[i].exp);
      check({vecs[i].name, "_lat"}, 128'(lat), 128'd5);
      check({vecs[i].name, "_idle"}, 128'({in_ready, out_valid, busy}), 128'b100);
    end

    // Back-pressure in DONE.
    @(negedge clk);
    in_data = SEQ_0F; in_inv = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    wait_valid(lat);
    check("bp_lat", 128'(lat), 128'd5);
    hold = out_data;
    check("bp_first", hold, FWD_0F);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check("bp_valid", 128'(out_valid), 128'd1);
      check("bp_data", out_data, FWD_0F);
      check("bp_ready", 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release", 128'({in_ready, out_valid, busy}), 128'b100);

    // Reset during the second ISSUE cycle.
    @(negedge clk);
    in_data = SEQ_1F; in_inv = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("mid_state", 128'(state_dbg), 128'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_flags", 128'({in_ready, out_valid, busy}), 128'b100);
    check("mid_data", out_data, 128'd0);
    check("mid_idle", 128'(state_dbg), 128'd0);
    run_state(SEQ_1F, 1'b0, res, lat);
    check("post_rst_data", res, FWD_1F);
    check("post_rst_lat", 128'(lat), 128'd5);

    // A second in_valid during ISSUE must be ignored.
    @(negedge clk);
    in_data = SEQ_0F; in_inv = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    @(posedge clk);
    lat++;
    #1;
    in_data  = {16{8'hff}};
    in_valid = 1'b1;
    check("ign_ready", 128'(in_ready), 128'd0);
    @(posedge clk);
    lat++;
    #1;
    in_valid = 1'b0;
    wait_valid(lat);
    check("ign_lat", 128'(lat), 128'd5);
    check("ign_data", out_data, FWD_0F);
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) begin
      check("ign_noqueue", 128'({out_valid, busy}), 128'b00);
      @(posedge clk);
      #1;
    end

    // LANES sweep: 16, 8 and 1 beats with all-0x53 input.
    exp_lat = '{17, 9, 2};
    for (int j = 0; j < 3; j++) begin
      sl[j] = 0;
      sd[j] = '0;
    end
    @(negedge clk);
    sw_valid = 1'b1;
    @(posedge clk);
    #1;
    sw_valid = 1'b0;
    for (int e = 1; e <= 25; e++) begin
      @(posedge clk);
      #1;
      for (int j = 0; j < 3; j++) begin
        if (sl[j] == 0 && sw_ovalid[j]) begin
          sl[j] = e;
          sd[j] = sw_odata[j];
        end
      end
    end
    for (int j = 0; j < 3; j++) begin
      check($sformatf("sweep%0d_lat", j), 128'(sl[j]), 128'(exp_lat[j]));
      check($sformatf("sweep%0d_data", j), sd[j], {16{8'hed}});
      check($sformatf("sweep%0d_idle", j), 128'({sw_ready[j], sw_busy[j]}), 128'b10);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
